// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared state encoding and derived-width helpers for the matrix
//            multiply stream engine.
// Revision : 1.0  initial release
// ============================================================================
package matmul_pkg;

    typedef enum logic [2:0] {
        LOAD_A     = 3'd0,
        LOAD_B     = 3'd1,
        COMPUTE    = 3'd2,
        SEND_ISSUE = 3'd3,
        SEND_GUARD = 3'd4,
        SEND_WAIT  = 3'd5
    } state_t;

    function automatic int calc_in_bytes(input int data_w);
        return (data_w + 7) / 8;
    endfunction

    function automatic int calc_acc_w(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    function automatic int calc_out_bytes(input int data_w, input int n);
        return (calc_acc_w(data_w, n) + 7) / 8;
    endfunction

    // Counter width for a range of 'depth' values, never narrower than one bit
    function automatic int calc_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ============================================================================
// Module   : matmul_mac
// Purpose  : DATA_W x DATA_W multiplier feeding an ACC_W accumulator; signed
//            arithmetic when MATMUL_SIGNED_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = calc_acc_w(8, 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_prod;

`ifdef MATMUL_SIGNED_EN
    assign w_prod = ACC_W'($signed(a)) * ACC_W'($signed(b));
`else
    assign w_prod = ACC_W'(a) * ACC_W'(b);
`endif

    // Sum is exposed combinationally so the final term can be stored the same cycle
    assign sum = clear ? w_prod : (r_acc + w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_engine
// Purpose  : Loads N x N matrices A and B from a byte stream, computes A*B
//            with one MAC per cycle and streams C out via start/busy.
//            Optional macro: MATMUL_SIGNED_EN (two's complement elements).
// Revision : 1.0  initial release
// ============================================================================
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_start,
    input  logic       out_busy,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int IN_BYTES  = calc_in_bytes(DATA_W);
    localparam int ACC_W     = calc_acc_w(DATA_W, N);
    localparam int OUT_BYTES = calc_out_bytes(DATA_W, N);
    localparam int c_NN      = N * N;
    localparam int c_IN_W    = IN_BYTES * 8;
    localparam int c_OUT_W   = OUT_BYTES * 8;
    localparam int c_IW      = calc_idx_w(N);
    localparam int c_EW      = calc_idx_w(c_NN);
    localparam int c_IBW     = calc_idx_w(IN_BYTES);
    localparam int c_OBW     = calc_idx_w(OUT_BYTES);

    state_t            r_state;
    logic [c_IBW-1:0]  r_bcnt;
    logic [c_EW-1:0]   r_ecnt;
    logic [c_IW-1:0]   r_i, r_j, r_k;
    logic [c_OBW-1:0]  r_obyte;
    logic [DATA_W-1:0] r_mem_a [c_NN];
    logic [DATA_W-1:0] r_mem_b [c_NN];
    logic [ACC_W-1:0]  r_mem_c [c_NN];

    logic [c_IN_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_elem;
    logic               w_loading, w_load, w_drop, w_elem_last, w_mat_last;
    logic               w_i_last, w_j_last, w_k_last;
    logic [c_EW-1:0]    w_a_idx, w_b_idx, w_c_idx;
    logic [ACC_W-1:0]   w_sum;
    logic [c_OUT_W-1:0] w_c_ext;
    logic [7:0]         w_tx_byte;

    // Byte assembly: the newest byte is always the least significant
    generate
        if (IN_BYTES > 1) begin : g_multi_byte
            logic [c_IN_W-9:0] r_shift;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shift <= '0;
                end else if (w_load) begin
                    r_shift <= w_word[c_IN_W-9:0];
                end
            end
            assign w_word = {r_shift, in_data};
        end else begin : g_single_byte
            assign w_word = in_data;
        end
    endgenerate

    assign w_elem      = w_word[DATA_W-1:0];
    assign w_loading   = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_load      = in_valid && w_loading;
    assign w_drop      = in_valid && !w_loading;
    assign w_elem_last = (r_bcnt == c_IBW'(IN_BYTES - 1));
    assign w_mat_last  = (r_ecnt == c_EW'(c_NN - 1));
    assign w_i_last    = (r_i == c_IW'(N - 1));
    assign w_j_last    = (r_j == c_IW'(N - 1));
    assign w_k_last    = (r_k == c_IW'(N - 1));
    assign w_a_idx     = c_EW'(r_i) * c_EW'(N) + c_EW'(r_k);
    assign w_b_idx     = c_EW'(r_k) * c_EW'(N) + c_EW'(r_j);
    assign w_c_idx     = c_EW'(r_i) * c_EW'(N) + c_EW'(r_j);

`ifdef MATMUL_SIGNED_EN
    assign w_c_ext = c_OUT_W'($signed(r_mem_c[r_ecnt]));
`else
    assign w_c_ext = c_OUT_W'(r_mem_c[r_ecnt]);
`endif
    assign w_tx_byte = 8'(w_c_ext >> (8 * (OUT_BYTES - 1 - int'(r_obyte))));

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (r_k == '0),
        .en    (r_state == COMPUTE),
        .a     (r_mem_a[w_a_idx]),
        .b     (r_mem_b[w_b_idx]),
        .sum   (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_load && w_elem_last) begin
                if (r_state == LOAD_A) begin
                    r_mem_a[r_ecnt] <= w_elem;
                end else begin
                    r_mem_b[r_ecnt] <= w_elem;
                end
            end
            if ((r_state == COMPUTE) && w_k_last) begin
                r_mem_c[w_c_idx] <= w_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOAD_A;
            r_bcnt    <= '0;
            r_ecnt    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_obyte   <= '0;
            out_start <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_start <= 1'b0;
            done      <= 1'b0;
            if (w_drop) begin
                overrun <= 1'b1;
            end
            case (r_state)
                LOAD_A, LOAD_B: begin
                    if (in_valid) begin
                        if ((r_state == LOAD_A) && (r_ecnt == '0) && (r_bcnt == '0)) begin
                            overrun <= 1'b0;
                        end
                        if (w_elem_last) begin
                            r_bcnt <= '0;
                            if (w_mat_last) begin
                                r_ecnt <= '0;
                                if (r_state == LOAD_A) begin
                                    r_state <= LOAD_B;
                                end else begin
                                    r_state <= COMPUTE;
                                    busy    <= 1'b1;
                                end
                            end else begin
                                r_ecnt <= r_ecnt + 1'b1;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (w_k_last) begin
                        r_k <= '0;
                        if (w_j_last) begin
                            r_j <= '0;
                            if (w_i_last) begin
                                r_i     <= '0;
                                r_state <= SEND_ISSUE;
                            end else begin
                                r_i <= r_i + 1'b1;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                SEND_ISSUE: begin
                    if (!out_busy) begin
                        out_start <= 1'b1;
                        out_data  <= w_tx_byte;
                        r_state   <= SEND_GUARD;
                    end
                end
                // The transmitter may take a cycle to raise busy after start
                SEND_GUARD: begin
                    r_state <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    if (!out_busy) begin
                        r_state <= SEND_ISSUE;
                        if (r_obyte == c_OBW'(OUT_BYTES - 1)) begin
                            r_obyte <= '0;
                            if (w_mat_last) begin
                                r_ecnt  <= '0;
                                r_state <= LOAD_A;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_ecnt <= r_ecnt + 1'b1;
                            end
                        end else begin
                            r_obyte <= r_obyte + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
